// File: rtl/ray_marcher_scheduler.sv
// Raster-order job dispatch across NUM_CORES ray marcher cores, round-robin result collection onto one BRAM write port.
// Optional SCHED_PERF_EN: frame_cycles_out reports START-to-new_frame_out cycle count (otherwise tied to 0).
module ray_marcher_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int ADDR_BITS      = 17
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_hold_in,
  input  logic [NUM_CORES-1:0]          core_ready_in,
  output logic [NUM_CORES-1:0]          core_start_out,
  output logic [H_BITS-1:0]             job_hcount_out,
  output logic [V_BITS-1:0]             job_vcount_out,
  input  logic [NUM_CORES-1:0]          core_valid_in,
  input  logic [NUM_CORES*H_BITS-1:0]   core_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]   core_vcount_in,
  input  logic [NUM_CORES*4-1:0]        core_color_in,
  output logic [NUM_CORES-1:0]          core_ack_out,
  output logic                          write_enable_out,
  output logic [ADDR_BITS-1:0]          write_addr_out,
  output logic [3:0]                    write_data_out,
  output logic                          new_frame_out,
  output logic [31:0]                   frame_cycles_out
);

  localparam int unsigned NC    = NUM_CORES;
  localparam int          PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned TOTAL = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int          CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {START, DISPATCH, DRAIN, HOLD} state_t;

  state_t               state;
  logic [PTR_W-1:0]     disp_ptr, coll_ptr, disp_idx, coll_idx;
  logic                 disp_found, coll_found;
  logic [NUM_CORES-1:0] eligible;
  logic [H_BITS-1:0]    pix_h, wr_h, sel_h;
  logic [V_BITS-1:0]    pix_v, wr_v, sel_v;
  logic [3:0]           sel_c;
  logic [CNT_W-1:0]     written, written_next;
  logic                 frame_done;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == NC - 1) ? '0 : p + 1'b1;
  endfunction

  // A core whose start is already on the wire still shows ready this cycle; skip it.
  assign eligible = core_ready_in & ~core_start_out;

  always_comb begin
    int unsigned k;
    k          = 0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      k = (32'(disp_ptr) + i) % NC;
      if (!disp_found && eligible[k]) begin
        disp_found = 1'b1;
        disp_idx   = PTR_W'(k);
      end
    end
  end

  always_comb begin
    int unsigned k;
    k          = 0;
    coll_found = 1'b0;
    coll_idx   = '0;
    sel_h      = '0;
    sel_v      = '0;
    sel_c      = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      k = (32'(coll_ptr) + i) % NC;
      if (!coll_found && core_valid_in[k]) begin
        coll_found = 1'b1;
        coll_idx   = PTR_W'(k);
        sel_h      = core_hcount_in[k*H_BITS +: H_BITS];
        sel_v      = core_vcount_in[k*V_BITS +: V_BITS];
        sel_c      = core_color_in[k*4 +: 4];
      end
    end
    core_ack_out = '0;
    if (coll_found && !rst_in) core_ack_out[coll_idx] = 1'b1;
  end

  assign written_next   = written + CNT_W'(write_enable_out);
  assign frame_done     = (state == DRAIN) && (written_next == CNT_W'(TOTAL));
  assign write_addr_out = ADDR_BITS'(wr_v) * ADDR_BITS'(DISPLAY_WIDTH) + ADDR_BITS'(wr_h);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= START;
      pix_h            <= '0;
      pix_v            <= '0;
      written          <= '0;
      disp_ptr         <= '0;
      coll_ptr         <= '0;
      core_start_out   <= '0;
      job_hcount_out   <= '0;
      job_vcount_out   <= '0;
      write_enable_out <= 1'b0;
      wr_h             <= '0;
      wr_v             <= '0;
      write_data_out   <= '0;
      new_frame_out    <= 1'b0;
    end else begin
      core_start_out   <= '0;
      new_frame_out    <= 1'b0;
      write_enable_out <= coll_found;
      if (coll_found) begin
        wr_h           <= sel_h;
        wr_v           <= sel_v;
        write_data_out <= sel_c;
        coll_ptr       <= next_ptr(coll_idx);
      end
      case (state)
        START: begin
          pix_h   <= '0;
          pix_v   <= '0;
          written <= '0;
          state   <= DISPATCH;
        end
        DISPATCH: begin
          written <= written_next;
          if (disp_found) begin
            core_start_out <= NUM_CORES'(1) << disp_idx;
            job_hcount_out <= pix_h;
            job_vcount_out <= pix_v;
            disp_ptr       <= next_ptr(disp_idx);
            if (pix_h == H_BITS'(DISPLAY_WIDTH - 1)) begin
              pix_h <= '0;
              if (pix_v == V_BITS'(DISPLAY_HEIGHT - 1)) state <= DRAIN;
              else pix_v <= pix_v + 1'b1;
            end else begin
              pix_h <= pix_h + 1'b1;
            end
          end
        end
        DRAIN: begin
          written <= written_next;
          if (frame_done) begin
            new_frame_out <= 1'b1;
            state         <= frame_hold_in ? HOLD : START;
          end
        end
        HOLD: begin
          if (!frame_hold_in) state <= START;
        end
        default: state <= START;
      endcase
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] perf_cnt;

  // perf_cnt holds the number of cycles elapsed since the START cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_cnt         <= '0;
      frame_cycles_out <= '0;
    end else begin
      if (state == START) perf_cnt <= 32'd1;
      else if (perf_cnt != '1) perf_cnt <= perf_cnt + 1'b1;
      if (frame_done) frame_cycles_out <= (perf_cnt == '1) ? '1 : perf_cnt + 1'b1;
    end
  end
`else
  assign frame_cycles_out = '0;
`endif

endmodule
